// File: rtl/adder_i4_o3_err_monitor.sv
// adder_i4_o3_err_monitor
// Exhaustive error monitor for a 2-bit + 2-bit approximate adder.
// One accepted start walks dut_in through 0..15, one vector per cycle,
// and compares the 3-bit adder response with the exact sum a + b.
//
// The sweep reports three results:
//   max_err    largest absolute error seen in the sweep
//   err_count  number of vectors with nonzero error, saturating at 16
//   pass       high when max_err <= ET
//
// Optional feature: define ADDER_ERR_MON_FIRSTFAIL_EN to add
// first_fail_valid and first_fail_vec. These latch the first vector in a
// sweep whose error exceeds ET.
//
// Timing: start edge, 16 SWEEP cycles, then one DONE cycle. The done pulse
// therefore lands in cycle 18.

module adder_i4_o3_err_monitor #(
   parameter int unsigned ET = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   output logic [3:0] dut_in,
   input  logic [2:0] dut_out,
   output logic       busy,
   output logic       done,
   output logic [2:0] max_err,
   output logic [4:0] err_count,
   output logic       pass
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
   ,
   output logic       first_fail_valid,
   output logic [3:0] first_fail_vec
`endif
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [2:0] ET_LIM   = 3'(ET);
   localparam logic [4:0] CNT_SAT  = 5'd16;
   localparam logic [3:0] LAST_VEC = 4'hF;

   state_t     state;
   state_t     state_next;

   logic [1:0] op_a;
   logic [1:0] op_b;
   logic [2:0] exact_sum;
   logic [2:0] vec_err;
   logic [2:0] max_next;
   logic       accept;

   // Operand split and exact reference sum for the vector on dut_in.
   assign op_a      = dut_in[1:0];
   assign op_b      = dut_in[3:2];
   assign exact_sum = {1'b0, op_a} + {1'b0, op_b};

   // Absolute error of the sampled response, plus the running maximum
   // that includes this vector.
   always_comb begin
      if (dut_out >= exact_sum) begin
         vec_err = dut_out - exact_sum;
      end else begin
         vec_err = exact_sum - dut_out;
      end
      max_next = (vec_err > max_err) ? vec_err : max_err;
   end

   // Status outputs decode straight from the state register. An
   // asynchronous reset therefore drops them immediately.
   assign busy   = (state != IDLE);
   assign done   = (state == DONE);
   assign accept = (state == IDLE) && start;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the pre-edge values no matter the statement order.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. start is only looked at in IDLE, so a start pulse
   // during SWEEP or DONE has no effect.
   always_comb begin
      // NOTE: assigning a default first keeps every path assigned, so no
      // latch is inferred when a case arm leaves the signal alone.
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = SWEEP;
            end
         end
         SWEEP: begin
            if (dut_in == LAST_VEC) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Sweep datapath: vector counter and result accumulators.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: these are a handful of flops, not a memory. All of them are
      // reset so the outputs read zero as soon as rst rises.
      if (rst) begin
         dut_in    <= '0;
         max_err   <= '0;
         err_count <= '0;
         pass      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dut_in    <= '0;
                  max_err   <= '0;
                  err_count <= '0;
                  pass      <= 1'b0;
               end
            end
            SWEEP: begin
               max_err <= max_next;
               if ((vec_err != 3'd0) && (err_count != CNT_SAT)) begin
                  err_count <= err_count + 5'd1;
               end
               // Wraps from 15 back to 0 on the final vector.
               dut_in <= dut_in + 4'd1;
            end
            DONE: begin
               // max_err already includes vector 15 by the time DONE is reached.
               pass <= (max_err <= ET_LIM);
            end
            default: begin
               dut_in <= '0;
            end
         endcase
      end
   end

`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
   // Latch the first vector of the sweep whose error exceeds the limit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if (accept) begin
         first_fail_valid <= 1'b0;
         first_fail_vec   <= '0;
      end else if ((state == SWEEP) && !first_fail_valid && (vec_err > ET_LIM)) begin
         first_fail_valid <= 1'b1;
         first_fail_vec   <= dut_in;
      end
   end
`endif

endmodule

// File: tb/tb_adder_i4_o3_err_monitor.sv
// Testbench for adder_i4_o3_err_monitor.
//
// Two monitors run side by side, one with ET=1 and one with ET=0. Each one
// is fed by a behavioural "approximate adder": a 16-entry response table
// indexed by that monitor's own dut_in.
//
// Expected results come from a reference model. The model walks the
// response table with plain integer arithmetic.

module tb_adder_i4_o3_err_monitor;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;

   logic [3:0] dut_in1, dut_in0;
   logic [2:0] dut_out1, dut_out0;
   logic       busy1, busy0, done1, done0, pass1, pass0;
   logic [2:0] max_err1, max_err0;
   logic [4:0] err_count1, err_count0;
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
   logic       ffv1, ffv0;
   logic [3:0] ffvec1, ffvec0;
`endif

   logic [2:0] resp_lut [16];
   int         vectors     = 0;
   int         miscompares = 0;

   always #5 clk = ~clk;

   // Approximate adder model: a pure lookup on each monitor's own dut_in.
   assign dut_out1 = resp_lut[dut_in1];
   assign dut_out0 = resp_lut[dut_in0];

   adder_i4_o3_err_monitor #(.ET(1)) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dut_in    (dut_in1),
      .dut_out   (dut_out1),
      .busy      (busy1),
      .done      (done1),
      .max_err   (max_err1),
      .err_count (err_count1),
      .pass      (pass1)
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
      ,
      .first_fail_valid (ffv1),
      .first_fail_vec   (ffvec1)
`endif
   );

   adder_i4_o3_err_monitor #(.ET(0)) u_dut0 (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dut_in    (dut_in0),
      .dut_out   (dut_out0),
      .busy      (busy0),
      .done      (done0),
      .max_err   (max_err0),
      .err_count (err_count0),
      .pass      (pass0)
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
      ,
      .first_fail_valid (ffv0),
      .first_fail_vec   (ffvec0)
`endif
   );

   // One comparison: count it, and on mismatch count and report it.
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference model: sweep all 16 operand pairs through the response table.
   task automatic model(input int et, output int e_max, output int e_cnt,
                        output int e_pass, output int e_ffv, output int e_ffvec);
      e_max = 0; e_cnt = 0; e_ffv = 0; e_ffvec = 0;
      for (int v = 0; v < 16; v++) begin
         int a, b, r, err;
         a   = v % 4;
         b   = v / 4;
         r   = int'(resp_lut[v]);
         err = (r > a + b) ? r - (a + b) : (a + b) - r;
         if (err > e_max) e_max = err;
         if (err != 0 && e_cnt < 16) e_cnt++;
         if (err > et && e_ffv == 0) begin
            e_ffv   = 1;
            e_ffvec = v;
         end
      end
      e_pass = (e_max <= et) ? 1 : 0;
   endtask

   task automatic set_lut(input int kind);
      for (int v = 0; v < 16; v++) begin
         case (kind)
            0:       resp_lut[v] = 3'(v % 4 + v / 4);
            1:       resp_lut[v] = 3'd0;
            2:       resp_lut[v] = 3'(v % 4 + v / 4 + 1);
            default: resp_lut[v] = 3'($urandom_range(0, 7));
         endcase
      end
   endtask

   task automatic check_results(input string tag);
      int m1, c1, p1, f1, fv1, m0, c0, p0, f0, fv0;
      model(1, m1, c1, p1, f1, fv1);
      model(0, m0, c0, p0, f0, fv0);
      check({tag, " max_err et1"},   32'(max_err1),   32'(m1));
      check({tag, " err_count et1"}, 32'(err_count1), 32'(c1));
      check({tag, " pass et1"},      32'(pass1),      32'(p1));
      check({tag, " max_err et0"},   32'(max_err0),   32'(m0));
      check({tag, " err_count et0"}, 32'(err_count0), 32'(c0));
      check({tag, " pass et0"},      32'(pass0),      32'(p0));
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
      check({tag, " ff_valid et1"}, 32'(ffv1),   32'(f1));
      check({tag, " ff_vec et1"},   32'(ffvec1), 32'(fv1));
      check({tag, " ff_valid et0"}, 32'(ffv0),   32'(f0));
      check({tag, " ff_vec et0"},   32'(ffvec0), 32'(fv0));
`endif
   endtask

   // Called at a negedge. Pulses start, then follows the sweep to done.
   // A nonzero disturb re-pulses start at that negedge index.
   task automatic run_sweep(input string tag, input int disturb);
      int cyc;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 1;
      check({tag, " busy after start"},    32'(busy1),      32'd1);
      check({tag, " cleared max_err"},     32'(max_err1),   32'd0);
      check({tag, " cleared err_count"},   32'(err_count1), 32'd0);
      check({tag, " cleared pass"},        32'(pass1),      32'd0);
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
      check({tag, " cleared ff_valid"},    32'(ffv1),       32'd0);
`endif
      while (!done1 && cyc < 40) begin
         check({tag, " dut_in order"}, 32'(dut_in1), 32'(cyc - 1));
         start = (cyc == disturb);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check({tag, " done latency"},  32'(cyc),    32'd17);
      check({tag, " done et0"},      32'(done0),  32'd1);
      check({tag, " busy in done"},  32'(busy1),  32'd1);
      check({tag, " dut_in wrap"},   32'(dut_in1), 32'd0);
      @(negedge clk);
      check({tag, " done one cycle"}, 32'(done1), 32'd0);
      check({tag, " idle busy"},      32'(busy1), 32'd0);
      check_results(tag);
   endtask

   initial begin
      int quiet_done;

      // Reset state.
      rst   = 1'b1;
      start = 1'b0;
      set_lut(0);
      repeat (2) @(negedge clk);
      check("reset busy",      32'(busy1),      32'd0);
      check("reset done",      32'(done1),      32'd0);
      check("reset dut_in",    32'(dut_in1),    32'd0);
      check("reset max_err",   32'(max_err1),   32'd0);
      check("reset err_count", 32'(err_count1), 32'd0);
      check("reset pass",      32'(pass1),      32'd0);

      // The start pulse is presented on the very first edge after release.
      rst = 1'b0;
      run_sweep("exact", 0);

      set_lut(1);
      run_sweep("zero", 0);

      set_lut(2);
      run_sweep("plus1", 0);

      // Random response table: once undisturbed, then with start
      // re-pulsed mid-sweep.
      set_lut(3);
      run_sweep("rand_a", 0);
      run_sweep("rand_a_restart", 6);

      // Results hold in IDLE.
      repeat (5) @(negedge clk);
      check_results("rand_a hold");

      // Reset in the middle of a sweep.
      set_lut(1);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst busy",      32'(busy1),      32'd0);
      check("midrst done",      32'(done1),      32'd0);
      check("midrst dut_in",    32'(dut_in1),    32'd0);
      check("midrst max_err",   32'(max_err1),   32'd0);
      check("midrst err_count", 32'(err_count1), 32'd0);
      check("midrst pass",      32'(pass1),      32'd0);
`ifdef ADDER_ERR_MON_FIRSTFAIL_EN
      check("midrst ff_valid",  32'(ffv1),       32'd0);
      check("midrst ff_vec",    32'(ffvec1),     32'd0);
`endif
      @(negedge clk);
      rst        = 1'b0;
      quiet_done = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done1 || busy1) quiet_done++;
      end
      check("midrst no done after abort", 32'(quiet_done), 32'd0);
      run_sweep("after_rst", 0);

      // A few more random response tables.
      for (int k = 0; k < 4; k++) begin
         set_lut(3);
         run_sweep($sformatf("rand_%0d", k), (k == 1) ? 3 : 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/adder_i4_o3_err_monitor.md
ADDER_I4_O3_ERR_MONITOR -- requirements
Module: adder_i4_o3_err_monitor

Interface
REQ-001 Parameter ET, default 1: maximum permitted absolute error, 0..7.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to begin an exhaustive sweep.
REQ-005 dut_in  output  4  vector driven to the approximate adder's in3..in0.
REQ-006 dut_out  input  3  approximate adder response {out2,out1,out0}; combinational from dut_in.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse when a sweep completes.
REQ-009 max_err  output  3  largest absolute error seen in the last sweep.
REQ-010 err_count  output  5  number of vectors with nonzero error, 0..16.
REQ-011 pass  output  1  high when max_err <= ET; valid only after done.

Function
REQ-012 Operands SHALL be a = {dut_in[1],dut_in[0]} and b = {dut_in[3],dut_in[2]}; exact = a + b, 3 bits, range 0..6.
REQ-013 Error per vector SHALL be |dut_out - exact|, both unsigned 3-bit, result 0..7.
REQ-014 FSM states SHALL be IDLE, SWEEP, DONE.
REQ-015 IDLE: on start=1, load dut_in=0, clear max_err, err_count and pass, go to SWEEP next edge.
REQ-016 SWEEP: each cycle, sample dut_out against current dut_in, update max_err = max(max_err, error), increment err_count when error != 0, then increment dut_in.
REQ-017 Exactly 16 vectors SHALL be checked, one per cycle, in order 0..15; after vector 15, go to DONE; dut_in wraps to 0.
REQ-018 DONE: assert done for exactly one cycle, set pass = (max_err <= ET) with the final vector included, return to IDLE.
REQ-019 Start-to-done latency SHALL be 18 cycles: start edge, 16 SWEEP cycles, DONE cycle.
REQ-020 busy SHALL be high in SWEEP and DONE, low in IDLE.
REQ-021 start during SWEEP or DONE SHALL be ignored, with no restart and no corruption.
REQ-022 max_err, err_count and pass SHALL hold their values in IDLE until the next accepted start.
REQ-023 err_count SHALL saturate at 16 and never wrap.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE, dut_in=0, busy=0, done=0, max_err=0, err_count=0, pass=0.
REQ-025 rst asserted mid-sweep SHALL abort the sweep with no done pulse; a new start is required after release.
REQ-026 The first start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-027 Macro ADDER_ERR_MON_FIRSTFAIL_EN, when defined, SHALL add outputs first_fail_valid (1) and first_fail_vec (4).
REQ-028 With the macro defined, the first vector in a sweep with error > ET SHALL be latched into first_fail_vec and first_fail_valid set; both SHALL be cleared on accepted start and on rst.
REQ-029 Without the macro, those ports and their logic SHALL NOT exist, and all other behaviour is identical.

Verification
REQ-030 Exact adder model on dut_out, start pulse -> done at cycle 18, max_err=0, err_count=0, pass=1.
REQ-031 dut_out tied to 0 -> err_count=15, max_err=6, pass=0; with FIRSTFAIL_EN, first_fail_vec=4'b0010 (a=2, b=0; vector 1 has error 1 <= ET).
REQ-032 dut_out = exact+1 -> err_count=16 (saturated), max_err=1, pass=1 with ET=1, pass=0 with ET=0.
REQ-033 start re-pulsed at SWEEP cycle 5 -> ignored, done still at cycle 18, results unchanged versus an undisturbed run.
REQ-034 rst pulsed at SWEEP cycle 8 -> all outputs 0 asynchronously, no done; a new start gives a full correct 18-cycle sweep.
